pending_request_encoder: RTL and testbench
==========================================

# pending_request_encoder

Sticky request collector and registered lowest-index-first selector with a valid/ready output handshake. It latches single-cycle request pulses into a pending vector and presents one eligible index at a time. The presented index is held stable until the consumer accepts it, and the accepted pending bit is then cleared. It sits directly downstream of the request sources and wraps the combinational lowest-set-bit selection in storage and flow control. Typical uses are interrupt or event funnels.

## Interface
- IW, default 4: number of request lines, ≥2. Index width is $clog2(IW).
- i_clk  in  1  clock; everything is rising-edge.
- i_areset  in  1  asynchronous, active-high reset.
- i_req  in  IW  request pulses. Any high bit sets the matching pending bit.
- i_mask  in  IW  1 = line ineligible for selection. Its pending bit is still kept.
- i_ready  in  1  consumer accepts o_idx when o_valid && i_ready.
- o_idx  out  $clog2(IW)  presented index, registered.
- o_valid  out  1  o_idx is valid, registered.
- o_pending  out  IW  pending register, registered.

## Operation
- **State.** The block holds pending[IW], plus an output stage with two states.
  - IDLE: o_valid = 0.
  - PRESENT: o_valid = 1, and o_idx is held.
- **Accept.** acc = o_valid && i_ready.
- **Served bit.** served = one-hot(o_idx) when acc, otherwise 0.
- **Pending update** (every cycle): pending_next = (pending & ~served) | i_req.
  - A request on the served bit in the accept cycle wins, so the bit stays set.
- **Candidate.** cand = pending_next & ~i_mask, with the bit of a currently held, not-accepted o_idx excluded. That bit is already presented, so exclusion avoids double issue.
- **Selection.** sel = lowest set bit index of cand. The LSB has the highest priority.
- **Transitions:**
  - IDLE, cand ≠ 0 → PRESENT, with o_idx ← sel.
  - IDLE, cand = 0 → IDLE.
  - PRESENT, !acc → PRESENT, with o_idx and o_valid unchanged, whatever i_req or i_mask do.
  - PRESENT, acc, cand ≠ 0 → PRESENT, with o_idx ← sel. This gives back-to-back issue with no bubble.
  - PRESENT, acc, cand = 0 → IDLE.
- **Mask behaviour.**
  - Setting the mask of the held index does not retract it. The held index stays presented until accepted.
  - Masked pending bits remain in o_pending. They become eligible in the first cycle their mask clears.
- **Re-presenting an accepted index.** An accepted index with a new request in the same cycle has its bit re-set. It can be reselected in the next selection if it is the lowest eligible bit.
- **Duplicate requests.** Repeated requests on an already-pending bit merge. There is no counting.
- **Reset.** Asserting i_areset at any time, including mid-handshake, immediately forces:
  - pending = 0
  - o_valid = 0
  - o_idx = 0
  - o_pending = 0
  - state = IDLE

  In-flight requests are dropped. The first selection is possible on the first rising edge after deassertion.
- **Index width.** o_idx is driven as the exact index truncated to $clog2(IW) bits. Non-power-of-2 IW never yields an index ≥ IW.

## Timing
- **Request to presentation.** A request sampled on edge k with the block idle and the line unmasked gives o_valid = 1 and o_idx valid after edge k (1-cycle latency).
- **o_pending.** Reflects a request one edge after it is sampled.
- **Throughput.** One accept per cycle while eligible bits remain.
- **Output stability.** o_idx/o_valid change only on a clock edge after an accept or from IDLE, or asynchronously on reset.
- **Consumer dependency.** No combinational path from i_ready to o_idx or o_valid. i_ready only affects register updates.
- **Simultaneous events in one cycle.** Accept, new requests and mask changes are all resolved by the pending_next/cand equations above.

## Test plan
1. **Reset and single request.** Assert i_areset, then release. Pulse i_req=4'b0100 for one cycle with i_ready=1.
   - After reset: all outputs 0.
   - Cycle after the pulse: o_valid=1, o_idx=2, o_pending=0100.
   - Next cycle: o_valid=0, o_pending=0000.
2. **Priority and back-to-back drain.** i_req=4'b1011 in one cycle, i_ready=1.
   - Output sequence: o_idx 0, 1, 3 on three consecutive cycles with o_valid=1.
   - Then o_valid=0 and o_pending=0000.
3. **Stall and mask hold.** i_ready=0, i_req=4'b0010 → o_idx=1.
   - Then i_req=4'b0001 and i_mask=4'b0010 for 3 cycles: o_idx stays 1, o_valid stays 1, o_pending=0011.
   - i_ready=1: accept 1, then present 0.
4. **Masked pending.** i_mask=4'b0001, i_req=4'b0001.
   - o_valid stays 0 and o_pending=0001.
   - Clear the mask: o_valid=1, o_idx=0 one edge later.
5. **Same-bit re-request.** While idx 2 is presented, drive i_ready=1 and i_req=4'b0100 in the same cycle.
   - o_pending stays 0100.
   - o_idx=2 is presented again next cycle.
6. **Reset mid-operation.** With o_valid=1 and o_pending=1110, assert i_areset between clock edges.
   - o_valid, o_idx and o_pending go to 0 immediately.
   - After release with no requests: o_valid stays 0.

Source files
------------

// File: rtl/pending_request_encoder.sv
// Sticky request collector with a registered lowest-index-first selector
// and a valid/ready output handshake; the presented index is held until accepted.
module pending_request_encoder #(
    parameter int IW = 4
) (
    input  logic                  i_clk,
    input  logic                  i_areset,
    input  logic [IW-1:0]         i_req,
    input  logic [IW-1:0]         i_mask,
    input  logic                  i_ready,
    output logic [$clog2(IW)-1:0] o_idx,
    output logic                  o_valid,
    output logic [IW-1:0]         o_pending
);

    localparam int IDXW = $clog2(IW);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic [IW-1:0]   pending_q, pending_d;

    logic            acc;
    logic [IW-1:0]   served;
    logic [IW-1:0]   held;
    logic [IW-1:0]   cand;
    logic [IDXW-1:0] sel;

    always_comb begin
        acc = (state_q == PRESENT) && i_ready;

        served = '0;
        held   = '0;
        for (int i = 0; i < IW; i++) begin
            served[i] = acc && (idx_q == IDXW'(i));
            held[i]   = (state_q == PRESENT) && !acc && (idx_q == IDXW'(i));
        end

        // A new request on the bit being served wins over the clear.
        pending_d = (pending_q & ~served) | i_req;

        // The held index is excluded so it cannot be issued twice.
        cand = pending_d & ~i_mask & ~held;

        // Scan from the top so the lowest set bit is the last one written.
        sel = '0;
        for (int i = IW - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel = IDXW'(i);
            end
        end

        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (cand != '0) begin
                    state_d = PRESENT;
                    idx_d   = sel;
                end
            end
            PRESENT: begin
                if (acc) begin
                    if (cand != '0) begin
                        idx_d = sel;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_areset) begin
        if (i_areset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
        end
    end

    assign o_idx     = idx_q;
    assign o_valid   = (state_q == PRESENT);
    assign o_pending = pending_q;

endmodule

// File: tb/tb_pending_request_encoder.sv
// Directed-vector bench for pending_request_encoder (IW = 4) with
// hand-computed expectations for every sampled output.
module tb_pending_request_encoder;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] mask;
    logic       ready;
    logic [1:0] idx;
    logic       valid;
    logic [3:0] pending;

    int checks;
    int errors;

    pending_request_encoder #(.IW(4)) dut (
        .i_clk     (clk),
        .i_areset  (rst),
        .i_req     (req),
        .i_mask    (mask),
        .i_ready   (ready),
        .o_idx     (idx),
        .o_valid   (valid),
        .o_pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input int v, input int i, input int p);
        check({tag, ".valid"}, int'(valid), v);
        if (v == 1) check({tag, ".idx"}, int'(idx), i);
        check({tag, ".pending"}, int'(pending), p);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        req    = 4'b0000;
        mask   = 4'b0000;
        ready  = 1'b0;

        // 1: reset then a single request
        #12;
        check("rst.valid", int'(valid), 0);
        check("rst.idx", int'(idx), 0);
        check("rst.pending", int'(pending), 0);
        rst = 1'b0;
        step();
        req = 4'b0100; ready = 1'b1;
        step();
        expect_out("t1.present", 1, 2, 4'b0100);
        req = 4'b0000;
        step();
        expect_out("t1.drain", 0, 0, 4'b0000);

        // 2: priority and back-to-back drain
        req = 4'b1011;
        step();
        expect_out("t2.c0", 1, 0, 4'b1011);
        req = 4'b0000;
        step();
        expect_out("t2.c1", 1, 1, 4'b1010);
        step();
        expect_out("t2.c2", 1, 3, 4'b1000);
        step();
        expect_out("t2.end", 0, 0, 4'b0000);

        // 3: stall with the held index masked
        ready = 1'b0; req = 4'b0010;
        step();
        expect_out("t3.present", 1, 1, 4'b0010);
        req = 4'b0001; mask = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            step();
            expect_out($sformatf("t3.hold%0d", k), 1, 1, 4'b0011);
        end
        req = 4'b0000; ready = 1'b1;
        step();
        expect_out("t3.next", 1, 0, 4'b0001);
        step();
        expect_out("t3.end", 0, 0, 4'b0000);
        mask = 4'b0000;

        // 4: masked pending bit becomes eligible when unmasked
        mask = 4'b0001; req = 4'b0001;
        step();
        expect_out("t4.masked0", 0, 0, 4'b0001);
        req = 4'b0000;
        step();
        expect_out("t4.masked1", 0, 0, 4'b0001);
        mask = 4'b0000;
        step();
        expect_out("t4.unmask", 1, 0, 4'b0001);
        step();
        expect_out("t4.end", 0, 0, 4'b0000);

        // 5: re-request on the bit being accepted
        ready = 1'b0; req = 4'b0100;
        step();
        expect_out("t5.present", 1, 2, 4'b0100);
        ready = 1'b1; req = 4'b0100;
        step();
        expect_out("t5.again", 1, 2, 4'b0100);
        req = 4'b0000;
        step();
        expect_out("t5.end", 0, 0, 4'b0000);

        // 6: asynchronous reset mid-handshake
        ready = 1'b0; req = 4'b1110;
        step();
        expect_out("t6.present", 1, 1, 4'b1110);
        req = 4'b0000;
        #2;
        rst = 1'b1;
        #1;
        check("t6.rst.valid", int'(valid), 0);
        check("t6.rst.idx", int'(idx), 0);
        check("t6.rst.pending", int'(pending), 0);
        #1;
        rst = 1'b0;
        step();
        expect_out("t6.after0", 0, 0, 4'b0000);
        step();
        expect_out("t6.after1", 0, 0, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
